// File: rtl/mem_responder_pkg.sv
// Shared types for the LC-3b memory responder.
//   lc3b_word / lc3b_mem_wmask : datapath word and byte-write mask
//   resp_state_e               : responder FSM states
//   mem_req_t                  : captured request payload
package mem_responder_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } resp_state_e;

    localparam int unsigned MEM_DEFAULT_LATENCY = 3;
    localparam int unsigned CNT_BITS            = 4;

    typedef struct packed {
        lc3b_word      addr;
        lc3b_word      wdata;
        lc3b_mem_wmask be;
        logic          write;
    } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed RAM with byte-write enables, a registered read port and a
// full-word backdoor write port.
//   clk, rst          : clock, synchronous reset (read register only)
//   addr, we, be, wdata, re, rdata : functional port, rdata registered
//   init_we, init_addr, init_data  : backdoor full-word write
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  lc3b_mem_wmask        be,
    input  lc3b_word             wdata,
    input  logic                 re,
    output lc3b_word             rdata,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  lc3b_word             init_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    lc3b_word mem [DEPTH];

    // Storage is not reset; the backdoor write is last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
        end
        if (init_we) mem[init_addr] <= init_data;
    end

    // Read register holds until the next read.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// LC-3b memory-side responder: captures a read/write request, waits a fixed
// LATENCY, commits to the array and pulses mem_resp for one cycle.
//   clk, rst                      : clock, synchronous active-high reset
//   mem_address/read/write/byte_enable/wdata : request from CPU
//   mem_rdata, mem_resp           : registered response
//   busy, protocol_err            : status (protocol_err sticky until rst)
//   init_we/init_addr/init_data   : backdoor preload
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = MEM_DEFAULT_LATENCY,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  lc3b_word             mem_address,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  lc3b_mem_wmask        mem_byte_enable,
    input  lc3b_word             mem_wdata,
    output lc3b_word             mem_rdata,
    output logic                 mem_resp,
    output logic                 busy,
    output logic                 protocol_err,
    input  logic                 init_we,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  lc3b_word             init_data
);

    resp_state_e           state;
    logic [CNT_BITS-1:0]   cnt;
    mem_req_t              req;

    mem_req_t              cur_c;
    logic                  req_c;
    logic                  last_wait_c;
    logic                  commit_c;
    logic [ADDR_BITS-1:0]  idx_c;
    logic                  unused_addr_c;

    // In S_IDLE the live inputs are the transaction (needed when LATENCY==1
    // commits on the capture edge); afterwards the captured copy is used.
    always_comb begin
        req_c       = mem_read | mem_write;
        cur_c       = req;
        if (state == S_IDLE) begin
            cur_c = '{addr: mem_address, wdata: mem_wdata,
                      be: mem_byte_enable, write: mem_write};
        end
        last_wait_c = (state == S_WAIT) && (cnt == CNT_BITS'(1));
        commit_c    = !rst && (last_wait_c ||
                      ((state == S_IDLE) && req_c && (LATENCY == 1)));
        idx_c       = cur_c.addr[ADDR_BITS:1];
    end

    // Bit 0 and bits above ADDR_BITS are intentionally ignored (aliasing).
    assign unused_addr_c = ^cur_c.addr;

    mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk       (clk),
        .rst       (rst),
        .addr      (idx_c),
        .we        (commit_c & cur_c.write),
        .be        (cur_c.be),
        .wdata     (cur_c.wdata),
        .re        (commit_c & ~cur_c.write),
        .rdata     (mem_rdata),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // Responder FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            req          <= '0;
            mem_resp     <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_resp <= 1'b0;
                    if (req_c) begin
                        req  <= cur_c;
                        cnt  <= CNT_BITS'(LATENCY - 1);
                        busy <= 1'b1;
                        // Read+write together: executed as a write, flagged.
                        if (mem_read && mem_write) protocol_err <= 1'b1;
                        if (LATENCY == 1) begin
                            state    <= S_RESP;
                            mem_resp <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Initiator must hold its request until mem_resp.
                    if (!req_c) protocol_err <= 1'b1;
                    cnt <= cnt - CNT_BITS'(1);
                    if (last_wait_c) begin
                        state    <= S_RESP;
                        mem_resp <= 1'b1;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    mem_resp <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    mem_resp <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (LATENCY 3 and 1),
// a word-array reference model, an expected-response queue and a monitor.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned AB    = 10;
    localparam int unsigned DEPTH = 1 << AB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst             [2];
    lc3b_word      mem_address     [2];
    logic          mem_read        [2];
    logic          mem_write       [2];
    lc3b_mem_wmask mem_byte_enable [2];
    lc3b_word      mem_wdata       [2];
    lc3b_word      mem_rdata       [2];
    logic          mem_resp        [2];
    logic          busy            [2];
    logic          perr            [2];
    logic          init_we         [2];
    logic [AB-1:0] init_addr       [2];
    lc3b_word      init_data       [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_responder #(.LATENCY(g == 0 ? 3 : 1), .ADDR_BITS(AB)) u_dut (
            .clk             (clk),
            .rst             (rst[g]),
            .mem_address     (mem_address[g]),
            .mem_read        (mem_read[g]),
            .mem_write       (mem_write[g]),
            .mem_byte_enable (mem_byte_enable[g]),
            .mem_wdata       (mem_wdata[g]),
            .mem_rdata       (mem_rdata[g]),
            .mem_resp        (mem_resp[g]),
            .busy            (busy[g]),
            .protocol_err    (perr[g]),
            .init_we         (init_we[g]),
            .init_addr       (init_addr[g]),
            .init_data       (init_data[g])
        );
    end

    typedef struct packed {
        logic [1:0]  d;
        logic        is_read;
        lc3b_word    rdata;
        logic [31:0] cyc;
    } exp_t;

    exp_t     q [$];
    exp_t     me;
    lc3b_word model   [2][DEPTH];
    lc3b_word last_rd [2];
    logic     err_m   [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // Monitor: every response pops one expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_resp[d] === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", d, 32'd1, 32'd0);
                end else begin
                    me = q.pop_front();
                    chk("resp_dut", d, 32'(d), 32'(me.d));
                    chk("resp_cycle", d, 32'(cyc), me.cyc);
                    chk(me.is_read ? "rdata" : "rdata_hold", d, 32'(mem_rdata[d]), 32'(me.rdata));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic init_write(input int d, input int idx, input lc3b_word v);
        init_we[d]   = 1'b1;
        init_addr[d] = AB'(idx);
        init_data[d] = v;
        model[d][idx] = v;
        @(posedge clk); #1;
        init_we[d] = 1'b0;
    endtask

    // Issue one transaction (caller is at posedge+#1), wait for its response.
    task automatic txn(input int d, input logic rd, input logic wr, input lc3b_word addr,
                       input lc3b_mem_wmask m, input lc3b_word wd, input bit drop);
        logic [AB-1:0] idx;
        int c0;
        int lat;
        bit got;
        exp_t e;
        idx = addr[AB:1];
        lat = (d == 0) ? 3 : 1;
        got = 1'b0;
        if (wr) begin
            if (m[0]) model[d][idx][7:0]  = wd[7:0];
            if (m[1]) model[d][idx][15:8] = wd[15:8];
            if (rd) err_m[d] = 1'b1;
        end else begin
            last_rd[d] = model[d][idx];
        end
        if (drop && lat > 1) err_m[d] = 1'b1;
        c0 = cyc;
        e.d = 2'(d); e.is_read = ~wr; e.rdata = last_rd[d]; e.cyc = 32'(c0 + lat);
        q.push_back(e);
        mem_read[d] = rd; mem_write[d] = wr; mem_address[d] = addr;
        mem_byte_enable[d] = m; mem_wdata[d] = wd;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            chk("busy", d, 32'(busy[d]), 32'(cyc != c0));
            if (mem_resp[d]) got = 1'b1;
            else if (drop && cyc == c0 + 1) begin
                mem_read[d] = 1'b0; mem_write[d] = 1'b0;
            end
        end
        if (!got) chk("resp_timeout", d, 32'd0, 32'd1);
        else      chk("protocol_err", d, 32'(perr[d]), 32'(err_m[d]));
        @(posedge clk); #1;
        mem_read[d] = 1'b0; mem_write[d] = 1'b0;
    endtask

    task automatic random_txns(input int d, input int n);
        logic rd;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0)
                init_write(d, int'($urandom_range(0, DEPTH - 1)), 16'($urandom));
            rd = 1'($urandom_range(0, 1));
            txn(d, rd, ~rd, 16'($urandom), 2'($urandom), 16'($urandom), 1'b0);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog dut0 actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; mem_address[d] = '0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
            mem_byte_enable[d] = '0; mem_wdata[d] = '0; init_we[d] = 1'b0;
            init_addr[d] = '0; init_data[d] = '0; last_rd[d] = '0; err_m[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_resp", d, 32'(mem_resp[d]), 32'd0);
            chk("reset_rdata", d, 32'(mem_rdata[d]), 32'd0);
            chk("reset_busy", d, 32'(busy[d]), 32'd0);
            chk("reset_perr", d, 32'(perr[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Preload both arrays with random contents.
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int d = 0; d < 2; d++) begin
                init_we[d] = 1'b1; init_addr[d] = AB'(i); init_data[d] = 16'($urandom);
                model[d][i] = init_data[d];
            end
            @(posedge clk); #1;
        end
        init_we[0] = 1'b0; init_we[1] = 1'b0;

        // LATENCY=3: basic read, odd address, aliasing.
        init_write(0, 5, 16'hBEEF);
        txn(0, 1'b1, 1'b0, 16'h000A, 2'b00, 16'h0, 1'b0);
        chk("read_beef", 0, 32'(mem_rdata[0]), 32'h0000BEEF);
        txn(0, 1'b1, 1'b0, 16'h000B, 2'b11, 16'h0, 1'b0);
        init_write(0, 0, 16'h5A5A);
        txn(0, 1'b1, 1'b0, 16'h0800, 2'b00, 16'h0, 1'b0);
        chk("alias_word0", 0, 32'(mem_rdata[0]), 32'h00005A5A);

        // Byte enables.
        init_write(0, 8, 16'hABCD);
        txn(0, 1'b0, 1'b1, 16'h0010, 2'b01, 16'h1234, 1'b0);
        txn(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0, 1'b0);
        chk("be01", 0, 32'(mem_rdata[0]), 32'h0000AB34);
        init_write(0, 8, 16'hABCD);
        txn(0, 1'b0, 1'b1, 16'h0010, 2'b10, 16'h1234, 1'b0);
        txn(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0, 1'b0);
        chk("be10", 0, 32'(mem_rdata[0]), 32'h000012CD);
        init_write(0, 8, 16'hABCD);
        txn(0, 1'b0, 1'b1, 16'h0010, 2'b00, 16'h1234, 1'b0);
        txn(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0, 1'b0);
        chk("be00", 0, 32'(mem_rdata[0]), 32'h0000ABCD);

        // Back-to-back fetch / store / load to one address.
        txn(0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0, 1'b0);
        idle(1);
        txn(0, 1'b0, 1'b1, 16'h0020, 2'b11, 16'h7777, 1'b0);
        idle(1);
        txn(0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0, 1'b0);
        txn(0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0, 1'b0);
        chk("b2b_readback", 0, 32'(mem_rdata[0]), 32'h00007777);

        // Protocol errors: read+write together, then request dropped in wait.
        txn(0, 1'b1, 1'b1, 16'h0030, 2'b11, 16'h4321, 1'b0);
        txn(0, 1'b1, 1'b0, 16'h0030, 2'b00, 16'h0, 1'b1);
        chk("both_high_write", 0, 32'(mem_rdata[0]), 32'h00004321);

        // Reset during the wait of a pending write.
        init_write(0, 16'h20, 16'h0000);
        mem_write[0] = 1'b1; mem_address[0] = 16'h0040; mem_byte_enable[0] = 2'b11;
        mem_wdata[0] = 16'hFFFF;
        @(posedge clk); #1;
        rst[0] = 1'b1; mem_write[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0; err_m[0] = 1'b0; last_rd[0] = '0;
        @(negedge clk);
        chk("rst_mid_resp", 0, 32'(mem_resp[0]), 32'd0);
        chk("rst_mid_rdata", 0, 32'(mem_rdata[0]), 32'd0);
        chk("rst_mid_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_mid_perr", 0, 32'(perr[0]), 32'd0);
        idle(5);
        txn(0, 1'b1, 1'b0, 16'h0040, 2'b11, 16'h0, 1'b0);
        chk("rst_mid_discard", 0, 32'(mem_rdata[0]), 32'd0);

        random_txns(0, 150);

        // LATENCY=1 instance.
        init_write(1, 5, 16'hBEEF);
        txn(1, 1'b1, 1'b0, 16'h000A, 2'b00, 16'h0, 1'b0);
        chk("lat1_read", 1, 32'(mem_rdata[1]), 32'h0000BEEF);

        // Backdoor write wins over a functional write to the same word.
        model[1][16'h28] = 16'h2222;
        c0 = cyc;
        e.d = 2'd1; e.is_read = 1'b0; e.rdata = last_rd[1]; e.cyc = 32'(c0 + 1);
        q.push_back(e);
        mem_write[1] = 1'b1; mem_address[1] = 16'h0050; mem_byte_enable[1] = 2'b11;
        mem_wdata[1] = 16'h1111;
        init_we[1] = 1'b1; init_addr[1] = AB'(16'h28); init_data[1] = 16'h2222;
        @(posedge clk); #1;
        init_we[1] = 1'b0;
        @(negedge clk);
        chk("collision_resp", 1, 32'(mem_resp[1]), 32'd1);
        @(posedge clk); #1;
        mem_write[1] = 1'b0;
        txn(1, 1'b1, 1'b0, 16'h0050, 2'b00, 16'h0, 1'b0);
        chk("collision_init_wins", 1, 32'(mem_rdata[1]), 32'h00002222);

        random_txns(1, 100);
        txn(1, 1'b1, 1'b1, 16'h0060, 2'b11, 16'h9999, 1'b0);
        txn(1, 1'b1, 1'b0, 16'h0060, 2'b00, 16'h0, 1'b0);

        idle(3);
        chk("queue_drained", 0, 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
